// File: rtl/apb_cmd_master.sv
// Command-to-APB bridge: accepts one command, runs a single APB transfer
// (with optional ACCESS-phase timeout) and returns a held response.
module apb_cmd_master #(
  parameter int unsigned AW      = 12,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TOW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [31:0]   cmd_wdata,
  input  logic [3:0]    cmd_strb,
  input  logic [2:0]    cmd_prot,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic [AW-1:0] PADDR,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [3:0]    PSTRB,
  output logic [2:0]    PPROT,
  output logic [31:0]   PWDATA,
  output logic          APBACTIVE,
  input  logic [31:0]   PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam bit             TMO_EN   = (TIMEOUT != 32'd0);
  localparam logic [TOW-1:0] TMO_LAST = TOW'((TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1);
  localparam logic [TOW-1:0] CNT_MAX  = {TOW{1'b1}};

  state_t          state_r;
  logic [TOW-1:0]  tmo_cnt_r;
  logic            psel_r;
  logic            penable_r;
  logic            pwrite_r;
  logic [AW-1:0]   paddr_r;
  logic [3:0]      pstrb_r;
  logic [2:0]      pprot_r;
  logic [31:0]     pwdata_r;
  logic            rsp_valid_r;
  logic [31:0]     rsp_rdata_r;
  logic            rsp_err_r;
  logic            rsp_timeout_r;
  logic            tmo_hit_s;

  // Abort fires on the last permitted wait cycle; PREADY in that cycle still wins.
  assign tmo_hit_s = TMO_EN && (state_r == ACCESS) && !PREADY && (tmo_cnt_r == TMO_LAST);

  assign cmd_ready   = (state_r == IDLE) && !reset;
  assign APBACTIVE   = (state_r != IDLE) || cmd_valid;
  assign PSEL        = psel_r;
  assign PENABLE     = penable_r;
  assign PWRITE      = pwrite_r;
  assign PADDR       = paddr_r;
  assign PSTRB       = pstrb_r;
  assign PPROT       = pprot_r;
  assign PWDATA      = pwdata_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;

  // Transfer FSM with captured command fields, timeout counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      tmo_cnt_r     <= '0;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= '0;
      pstrb_r       <= 4'b0000;
      pprot_r       <= 3'b000;
      pwdata_r      <= 32'h0000_0000;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= 32'h0000_0000;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            pwrite_r <= cmd_write;
            paddr_r  <= cmd_addr;
            pstrb_r  <= cmd_write ? cmd_strb : 4'b0000;
            pprot_r  <= cmd_prot;
            pwdata_r <= cmd_wdata;
            psel_r   <= 1'b1;
            state_r  <= SETUP;
          end
        end
        SETUP: begin
          penable_r <= 1'b1;
          tmo_cnt_r <= '0;
          state_r   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata_r   <= pwrite_r ? 32'h0000_0000 : PRDATA;
            rsp_err_r     <= PSLVERR;
            rsp_timeout_r <= 1'b0;
            rsp_valid_r   <= 1'b1;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            state_r       <= RESP;
          end else if (tmo_hit_s) begin
            rsp_rdata_r   <= 32'h0000_0000;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
            rsp_valid_r   <= 1'b1;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            state_r       <= RESP;
          end else if (tmo_cnt_r != CNT_MAX) begin
            tmo_cnt_r <= tmo_cnt_r + TOW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          psel_r      <= 1'b0;
          penable_r   <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master (TIMEOUT=4): latency, waits, errors,
// timeout abort, response backpressure and mid-transfer reset.
module tb_apb_cmd_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [11:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PWDATA;
  logic        APBACTIVE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int errors = 0;
  int checks = 0;

  apb_cmd_master #(.AW(12), .TIMEOUT(4), .TOW(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PPROT(PPROT), .PWDATA(PWDATA), .APBACTIVE(APBACTIVE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command in the current IDLE cycle; returns in the SETUP cycle.
  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // Zero-wait transfer with given completer response; returns in the next IDLE cycle.
  task automatic xfer0(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] prd, input logic perr,
                       output logic v, output logic [31:0] rd, output logic e, output logic t);
    rsp_ready = 1'b1;
    issue(w, a, d, 4'hF, 3'b000);
    PREADY = 1'b1; PRDATA = prd; PSLVERR = perr;
    step();
    step();
    v = rsp_valid; rd = rsp_rdata; e = rsp_err; t = rsp_timeout;
    PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready); end
    checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b exp 000", {PSEL, PENABLE, rsp_valid}); end
    checks++; if ({PADDR, PWRITE, PSTRB, PPROT, PWDATA} !== 52'h0) begin errors++; $display("FAIL rst_bus: got %h exp 0", {PADDR, PWRITE, PSTRB, PPROT, PWDATA}); end
    checks++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 34'h0) begin errors++; $display("FAIL rst_rsp: got %h exp 0", {rsp_rdata, rsp_err, rsp_timeout}); end
    checks++; if (APBACTIVE !== 1'b0) begin errors++; $display("FAIL rst_apbactive0: got %b exp 0", APBACTIVE); end
    cmd_valid = 1'b1; #1;
    checks++; if ({APBACTIVE, cmd_ready} !== 2'b10) begin errors++; $display("FAIL rst_apbactive1: got %b exp 10", {APBACTIVE, cmd_ready}); end
    cmd_valid = 1'b0;
    step();
    reset = 1'b0; #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    cmd_write = 1'b1; cmd_addr = 12'h010; cmd_wdata = 32'hDEAD_BEEF; cmd_strb = 4'hF; cmd_prot = 3'b010;
    cmd_valid = 1'b1; rsp_ready = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready: got %b exp 1", cmd_ready); end
    step();
    cmd_valid = 1'b0; PRDATA = 32'hFFFF_FFFF;
    checks++; if ({PSEL, PENABLE, cmd_ready, APBACTIVE} !== 4'b1001) begin errors++; $display("FAIL wr_setup_ctrl: got %b exp 1001", {PSEL, PENABLE, cmd_ready, APBACTIVE}); end
    checks++; if ({PADDR, PWRITE, PSTRB, PPROT} !== {12'h010, 1'b1, 4'hF, 3'b010}) begin errors++; $display("FAIL wr_setup_bus: got %h exp %h", {PADDR, PWRITE, PSTRB, PPROT}, {12'h010, 1'b1, 4'hF, 3'b010}); end
    checks++; if (PWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_setup_wdata: got %h exp deadbeef", PWDATA); end
    step();
    PREADY = 1'b1;
    checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin errors++; $display("FAIL wr_access_ctrl: got %b exp 110", {PSEL, PENABLE, rsp_valid}); end
    checks++; if (PWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_access_wdata: got %h exp deadbeef", PWDATA); end
    step();
    PREADY = 1'b0; PRDATA = 32'h0;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE} !== 5'b10000) begin errors++; $display("FAIL wr_resp_flags: got %b exp 10000", {rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp_rdata: got %h exp 0", rsp_rdata); end
    step();
    checks++; if ({rsp_valid, cmd_ready, APBACTIVE} !== 3'b010) begin errors++; $display("FAIL wr_back_idle: got %b exp 010", {rsp_valid, cmd_ready, APBACTIVE}); end
  endtask

  task automatic test_read_wait();
    rsp_ready = 1'b1;
    issue(1'b0, 12'h024, 32'h1111_2222, 4'hF, 3'b101);
    checks++; if ({PSTRB, PWRITE, PPROT, PENABLE} !== {4'h0, 1'b0, 3'b101, 1'b0}) begin errors++; $display("FAIL rd_setup_bus: got %b exp 000001010", {PSTRB, PWRITE, PPROT, PENABLE}); end
    checks++; if (PADDR !== 12'h024) begin errors++; $display("FAIL rd_setup_addr: got %h exp 024", PADDR); end
    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hDEAD_DEAD;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin errors++; $display("FAIL rd_wait_ctrl[%0d]: got %b exp 110", i, {PSEL, PENABLE, rsp_valid}); end
      checks++; if ({PADDR, PSTRB} !== {12'h024, 4'h0}) begin errors++; $display("FAIL rd_wait_addr[%0d]: got %h exp 0240", i, {PADDR, PSTRB}); end
      if (i == 3) begin PREADY = 1'b1; PRDATA = 32'h1234_5678; PSLVERR = 1'b0; end
    end
    step();
    PREADY = 1'b0; PRDATA = 32'h0;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin errors++; $display("FAIL rd_resp_flags: got %b exp 100", {rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_resp_rdata: got %h exp 12345678", rsp_rdata); end
    step();
  endtask

  task automatic test_slverr();
    logic v, e, t;
    logic [31:0] rd;
    xfer0(1'b0, 12'h0A0, 32'h0, 32'hA5A5_5A5A, 1'b1, v, rd, e, t);
    checks++; if ({v, e, t} !== 3'b110) begin errors++; $display("FAIL err_rd_flags: got %b exp 110", {v, e, t}); end
    checks++; if (rd !== 32'hA5A5_5A5A) begin errors++; $display("FAIL err_rd_rdata: got %h exp a5a55a5a", rd); end
    xfer0(1'b1, 12'h0A4, 32'h0F0F_0F0F, 32'hFFFF_0000, 1'b1, v, rd, e, t);
    checks++; if ({v, e, t} !== 3'b110) begin errors++; $display("FAIL err_wr_flags: got %b exp 110", {v, e, t}); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_wr_rdata: got %h exp 0", rd); end
  endtask

  task automatic test_timeout();
    logic v, e, t;
    logic [31:0] rd;
    rsp_ready = 1'b0;
    issue(1'b0, 12'h100, 32'h0, 4'h0, 3'b000);
    PREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin errors++; $display("FAIL to_access[%0d]: got %b exp 110", i, {PSEL, PENABLE, rsp_valid}); end
    end
    step();
    checks++; if ({PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout} !== 5'b00111) begin errors++; $display("FAIL to_abort_flags: got %b exp 00111", {PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_abort_rdata: got %h exp 0", rsp_rdata); end
    PREADY = 1'b1; PRDATA = 32'h0BAD_0BAD; PSLVERR = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if ({rsp_rdata, rsp_valid, rsp_err, rsp_timeout, PSEL} !== {32'h0, 4'b1110}) begin errors++; $display("FAIL to_late_pready[%0d]: got %h exp %h", i, {rsp_rdata, rsp_valid, rsp_err, rsp_timeout, PSEL}, {32'h0, 4'b1110}); end
    end
    PREADY = 1'b0; PRDATA = 32'h0; rsp_ready = 1'b1;
    step();
    xfer0(1'b0, 12'h104, 32'h0, 32'h0000_C0DE, 1'b0, v, rd, e, t);
    checks++; if ({v, e, t, rd} !== {3'b100, 32'h0000_C0DE}) begin errors++; $display("FAIL to_next_cmd: got %h exp %h", {v, e, t, rd}, {3'b100, 32'h0000_C0DE}); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    issue(1'b0, 12'h030, 32'h0, 4'h0, 3'b000);
    PREADY = 1'b1; PRDATA = 32'h55AA_1234;
    step();
    step();
    PREADY = 1'b0; PRDATA = 32'h0;
    cmd_write = 1'b1; cmd_addr = 12'h040; cmd_wdata = 32'h0000_00FF; cmd_strb = 4'b0011; cmd_prot = 3'b001;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, rsp_err, rsp_timeout, cmd_ready, PSEL, APBACTIVE} !== 6'b100001) begin errors++; $display("FAIL bp_hold_flags[%0d]: got %b exp 100001", i, {rsp_valid, rsp_err, rsp_timeout, cmd_ready, PSEL, APBACTIVE}); end
      checks++; if (rsp_rdata !== 32'h55AA_1234) begin errors++; $display("FAIL bp_hold_rdata[%0d]: got %h exp 55aa1234", i, rsp_rdata); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    checks++; if ({cmd_ready, rsp_valid, PSEL} !== 3'b100) begin errors++; $display("FAIL bp_idle_reentry: got %b exp 100", {cmd_ready, rsp_valid, PSEL}); end
    step();
    cmd_valid = 1'b0;
    checks++; if ({PSEL, PENABLE, PADDR, PWRITE, PSTRB} !== {2'b10, 12'h040, 1'b1, 4'b0011}) begin errors++; $display("FAIL bp_second_setup: got %h exp %h", {PSEL, PENABLE, PADDR, PWRITE, PSTRB}, {2'b10, 12'h040, 1'b1, 4'b0011}); end
    PREADY = 1'b1;
    step();
    step();
    PREADY = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin errors++; $display("FAIL bp_second_resp: got %h exp %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0}); end
    step();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    issue(1'b0, 12'h200, 32'h0, 4'h0, 3'b000);
    PREADY = 1'b0;
    step();
    checks++; if ({PSEL, PENABLE} !== 2'b11) begin errors++; $display("FAIL rm_access: got %b exp 11", {PSEL, PENABLE}); end
    #1 reset = 1'b1; PREADY = 1'b1; PRDATA = 32'h7777_7777;
    #1;
    checks++; if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0000) begin errors++; $display("FAIL rm_async_drop: got %b exp 0000", {PSEL, PENABLE, cmd_ready, rsp_valid}); end
    step();
    reset = 1'b0; #1;
    checks++; if ({cmd_ready, rsp_valid, PSEL} !== 3'b100) begin errors++; $display("FAIL rm_release: got %b exp 100", {cmd_ready, rsp_valid, PSEL}); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({rsp_valid, PSEL, PENABLE} !== 3'b000) begin errors++; $display("FAIL rm_no_rsp[%0d]: got %b exp 000", i, {rsp_valid, PSEL, PENABLE}); end
    end
    PREADY = 1'b0; PRDATA = 32'h0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0; cmd_wdata = 32'h0;
    cmd_strb = 4'h0; cmd_prot = 3'b000; rsp_ready = 1'b1;
    PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameters SHALL be: AW, 12, APB address width; TIMEOUT, 255, max ACCESS wait cycles before abort (0 = timeout disabled); TOW, 8, timeout counter width (TIMEOUT < 2^TOW).
REQ-002 Ports, in order, SHALL be:
  clk  in  1  sole clock, all flops rising-edge;
  reset  in  1  asynchronous, active-high reset;
  cmd_valid  in  1  command request;
  cmd_ready  out  1  command accepted when high with cmd_valid;
  cmd_write  in  1  1 = write, 0 = read;
  cmd_addr  in  AW  target address;
  cmd_wdata  in  32  write data;
  cmd_strb  in  4  write byte strobes;
  cmd_prot  in  3  protection attributes;
  rsp_valid  out  1  response available;
  rsp_ready  in  1  response consumed when high with rsp_valid;
  rsp_rdata  out  32  read data (0 for writes and timeouts);
  rsp_err  out  1  PSLVERR seen or timeout;
  rsp_timeout  out  1  transfer aborted by timeout;
  PADDR  out  AW;  PSEL  out  1;  PENABLE  out  1;  PWRITE  out  1;
  PSTRB  out  4;  PPROT  out  3;  PWDATA  out  32;
  APBACTIVE  out  1  bus-active hint for clock gating;
  PRDATA  in  32;  PREADY  in  1;  PSLVERR  in  1.
REQ-003 Clock and reset SHALL be exactly as decided: one clock (clk); reset asynchronous, active-high (reset).

Function
REQ-004 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; one APB transfer outstanding at most.
REQ-005 cmd_ready SHALL be 1 only in IDLE with reset low; handshake cmd_valid&cmd_ready captures all cmd_* fields and moves IDLE->SETUP.
REQ-006 SETUP: PSEL=1, PENABLE=0; next cycle unconditionally ->ACCESS.
REQ-007 ACCESS: PSEL=1, PENABLE=1; PREADY=1 -> capture response, ->RESP, PSEL/PENABLE low the following cycle.
REQ-008 PADDR, PWRITE, PPROT, PWDATA, PSTRB SHALL be driven from capture registers, stable from SETUP through the last ACCESS cycle; PSTRB SHALL be 4'b0000 for reads.
REQ-009 PSEL and PENABLE SHALL be driven directly from flops (no combinational path from any input).
REQ-010 Response capture on PREADY: rsp_rdata=PRDATA for reads, 0 for writes; rsp_err=PSLVERR; rsp_timeout=0. PRDATA/PSLVERR SHALL be ignored unless state=ACCESS and PREADY=1.
REQ-011 Timeout counter SHALL clear on entry to ACCESS; each ACCESS cycle with PREADY=0: if TIMEOUT!=0 and count==TIMEOUT-1 -> abort, else count+1 (saturating at 2^TOW-1 when TIMEOUT=0).
REQ-012 Abort SHALL go ->RESP with rsp_rdata=0, rsp_err=1, rsp_timeout=1 and deassert PSEL/PENABLE next cycle; a later PREADY SHALL be ignored.
REQ-013 RESP: rsp_valid=1 with rsp_* held stable until rsp_ready=1; then ->IDLE. cmd_valid during RESP SHALL NOT be accepted.
REQ-014 Latency: command accepted at edge N -> PSEL high cycle N+1, PENABLE high N+2, zero-wait PREADY at N+2 -> rsp_valid high cycle N+3; minimum 4 cycles per transfer with rsp_ready=1.
REQ-015 APBACTIVE SHALL be 1 when state!=IDLE or cmd_valid=1, else 0.

Reset
REQ-016 With reset high: state=IDLE, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PSTRB=0, PPROT=0, PWDATA=0, timeout counter=0; APBACTIVE=cmd_valid.
REQ-017 Reset asserted mid-transfer SHALL drop PSEL/PENABLE immediately (asynchronously) and discard the pending transfer/response; no response issued after release.
REQ-018 First cycle after reset release SHALL have cmd_ready=1.

Verification
REQ-019 Zero-wait write addr 0x010, data 0xDEADBEEF, strb 0xF -> PSEL N+1, PENABLE N+2, PWDATA 0xDEADBEEF stable, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
REQ-020 Read 0x024 with PREADY low 3 ACCESS cycles then PRDATA 0x12345678 -> PSTRB=0, address stable 5 cycles, rsp_rdata=0x12345678, rsp_err=0.
REQ-021 Read with PSLVERR=1 on PREADY -> rsp_err=1, rsp_timeout=0; write with PSLVERR=1 -> rsp_err=1, rsp_rdata=0.
REQ-022 TIMEOUT=4, PREADY never high -> abort after 4th ACCESS cycle; rsp_err=1, rsp_timeout=1, PSEL low next cycle; late PREADY ignored; next command completes normally.
REQ-023 rsp_ready low 5 cycles with cmd_valid high -> rsp_* stable, cmd_ready=0 throughout; second command accepted first cycle after IDLE re-entry.
REQ-024 reset pulsed during ACCESS -> PSEL/PENABLE 0 same cycle, rsp_valid never asserts, cmd_ready=1 first cycle after release.
